// File: rtl/sync_fifo_bypass_req.sv
// rtl/sync_fifo_bypass_req.sv - request/grant FIFO with optional empty-path bypass
module sync_fifo_bypass_req #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int BYPASS_EN = 1,
    parameter int AFULL_TH  = DEPTH - 2
) (
    input  logic                       CLK,
    input  logic                       Reset_n,
    input  logic                       i_WrEn,
    input  logic [WIDTH-1:0]           i_WrData,
    input  logic                       i_Grant,
    input  logic                       i_Flush,
    input  logic                       i_OvfClr,
    output logic                       o_Req,
    output logic                       o_Valid,
    output logic [WIDTH-1:0]           o_Data,
    output logic [$clog2(DEPTH+1)-1:0] o_Count,
    output logic                       o_Empty,
    output logic                       o_Full,
    output logic                       o_AlmostFull,
    output logic                       o_Overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             grant_cyc;
    logic             pop;
    logic             bypass;
    logic             push;
    logic             drop;

    assign o_Req        = (o_Count != '0) | i_WrEn;
    assign o_Empty      = (o_Count == '0);
    assign o_Full       = (o_Count == CW'(DEPTH));
    assign o_AlmostFull = (o_Count >= CW'(AFULL_TH));

    // Flush masks every storage-side action so a same-cycle write or grant leaves no trace.
    always_comb begin
        grant_cyc = o_Req & i_Grant & ~i_Flush;
        pop       = grant_cyc & ~o_Empty;
        bypass    = grant_cyc & o_Empty & i_WrEn & (BYPASS_EN != 0);
        push      = i_WrEn & ~i_Flush & ~bypass & (~o_Full | pop);
        drop      = i_WrEn & ~i_Flush & o_Full & ~pop;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= i_WrData;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Valid    <= 1'b0;
            o_Data     <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (i_Flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                o_Count <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    o_Count <= o_Count + CW'(1);
                end else if (pop && !push) begin
                    o_Count <= o_Count - CW'(1);
                end
            end
            o_Valid <= pop | bypass;
            if (pop) begin
                o_Data <= mem[rd_ptr];
            end else if (bypass) begin
                o_Data <= i_WrData;
            end
            // A fresh drop outranks a clear issued in the same cycle.
            if (drop) begin
                o_Overflow <= 1'b1;
            end else if (i_OvfClr) begin
                o_Overflow <= 1'b0;
            end
        end
    end
endmodule
